// File: rtl/cnn_pkg.sv
// Shared convolution-datapath definitions: geometry, writer FSM states, pixel type.
package cnn_pkg;

    localparam int IMG_W = 28;
    localparam int K     = 3;
    localparam int OUT_W = IMG_W - K + 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } wr_state_e;

    typedef logic signed [7:0] pixel_t;

endpackage

// File: rtl/requant_sat.sv
// Accumulator to int8 requantizer: round-half-up, arithmetic shift, saturate.
// FMAP_WRITER_RELU_EN clamps negative results to zero before saturation.
module requant_sat
    import cnn_pkg::*;
#(
    parameter int ACC_W = 20,
    parameter int SHIFT = 7
) (
    input  logic signed [ACC_W-1:0] acc_i,
    output pixel_t                  pix_o
);

    localparam logic signed [ACC_W:0] RND     = (ACC_W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [ACC_W:0] PIX_MAX = (ACC_W+1)'(127);
    localparam logic signed [ACC_W:0] PIX_MIN = (ACC_W+1)'(-128);

    logic signed [ACC_W:0] sum;
    logic signed [ACC_W:0] shifted;

    always_comb begin
        // One extra bit so the rounding offset can never overflow
        sum     = $signed({acc_i[ACC_W-1], acc_i}) + RND;
        shifted = sum >>> SHIFT;
`ifdef FMAP_WRITER_RELU_EN
        if (shifted[ACC_W]) begin
            shifted = '0;
        end
`endif
        if (shifted > PIX_MAX) begin
            pix_o = 8'sh7f;
        end else if (shifted < PIX_MIN) begin
            pix_o = 8'sh80;
        end else begin
            pix_o = shifted[7:0];
        end
    end

endmodule

// File: rtl/fmap_writer.sv
// Writes a raster stream of requantized conv results into the feature-map BRAM.
// Build option FMAP_WRITER_RELU_EN (in requant_sat) restricts pixels to [0, 127].
//
// state   | meaning
// IDLE    | waiting for start, in_ready low
// RUN     | accepting one pixel per handshake
// DONE    | final pixel being written, frame_done high
module fmap_writer
    import cnn_pkg::*;
#(
    parameter int  OUT_W = cnn_pkg::OUT_W,
    parameter int  ACC_W = 20,
    parameter int  SHIFT = 7,
    localparam int NPIX  = OUT_W * OUT_W,
    localparam int AW    = $clog2(NPIX)
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    start,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [ACC_W-1:0] in_data,
    output logic [AW-1:0]           mem_addr,
    output logic signed [7:0]       mem_wdata,
    output logic                    mem_we,
    output logic                    busy,
    output logic                    frame_done
);

    localparam logic [AW-1:0] LAST = AW'(NPIX - 1);

    wr_state_e     state_q, state_d;
    logic [AW-1:0] cnt_q, cnt_d;
    logic [AW-1:0] addr_q;
    pixel_t        wdata_q;
    pixel_t        pix_rq;
    logic          we_q;
    logic          hs;

    requant_sat #(
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) u_requant (
        .acc_i (in_data),
        .pix_o (pix_rq)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hs      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_RUN;
                    cnt_d   = '0;
                end
            end
            ST_RUN: begin
                hs = in_valid;
                if (in_valid) begin
                    // Counter parks on the last address so it cannot wrap
                    if (cnt_q == LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            we_q    <= hs;
            if (hs) begin
                addr_q  <= cnt_q;
                wdata_q <= pix_rq;
            end
        end
    end

    assign in_ready   = (state_q == ST_RUN);
    assign busy       = (state_q != ST_IDLE);
    assign frame_done = (state_q == ST_DONE);
    assign mem_we     = we_q;
    assign mem_addr   = addr_q;
    assign mem_wdata  = wdata_q;

endmodule

// File: tb/tb_fmap_writer.sv
// Scoreboard bench for fmap_writer on a 4x4 frame with randomized pixel streams.
module tb_fmap_writer;

    localparam int OUT_W = 4;
    localparam int ACC_W = 20;
    localparam int SHIFT = 7;
    localparam int NPIX  = OUT_W * OUT_W;
    localparam int AW    = $clog2(NPIX);

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    start = 1'b0;
    logic                    in_valid = 1'b0;
    logic signed [ACC_W-1:0] in_data = '0;
    logic                    in_ready;
    logic [AW-1:0]           mem_addr;
    logic signed [7:0]       mem_wdata;
    logic                    mem_we;
    logic                    busy;
    logic                    frame_done;

    int n_vec = 0;
    int n_err = 0;

    typedef struct {
        int addr;
        int data;
        bit last;
    } exp_t;

    exp_t exp_q[$];
    int   m_phase  = 0;
    int   m_taken  = 0;
    int   m_frames = 0;
    int   n_fd     = 0;
    int   hold_a   = 0;
    int   hold_d   = 0;

    int rq_vals[5] = '{-200, 100000, -100000, 63, 64};
    bit bub[4]     = '{1'b1, 1'b0, 1'b0, 1'b1};

    fmap_writer #(
        .OUT_W (OUT_W),
        .ACC_W (ACC_W),
        .SHIFT (SHIFT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .busy       (busy),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference requantizer: floor((v + 2^(S-1)) / 2^S), then clamp
    function automatic int requant_ref(input logic signed [ACC_W-1:0] d);
        int v, q, r, div;
        v   = d;
        div = 1 << SHIFT;
        q   = v + (1 << (SHIFT - 1));
        r   = (q >= 0) ? q / div : -((-q + div - 1) / div);
`ifdef FMAP_WRITER_RELU_EN
        if (r < 0) r = 0;
`endif
        if (r > 127)  r = 127;
        if (r < -128) r = -128;
        return r;
    endfunction

    function automatic logic signed [ACC_W-1:0] gen_data();
        int v;
        case ($urandom_range(0, 3))
            0: v = int'($urandom_range(0, 800)) - 400;
            1: v = int'($urandom_range(0, 1048575)) - 524288;
            2: v = (int'($urandom_range(0, 40)) - 20) * 128 + 63 + int'($urandom_range(0, 1));
            default: v = int'($urandom_range(16000, 524287)) * (($urandom_range(0, 1) != 0) ? 1 : -1);
        endcase
        return ACC_W'(v);
    endfunction

    // Frame-level model: pixels accepted only while a frame is open
    always @(posedge clk or posedge reset) begin
        exp_t e;
        if (reset) begin
            m_phase = 0;
            m_taken = 0;
            exp_q.delete();
        end else begin
            case (m_phase)
                0: if (start) begin
                    m_phase = 1;
                    m_taken = 0;
                end
                1: if (in_valid) begin
                    e.addr = m_taken;
                    e.data = requant_ref(in_data);
                    e.last = (m_taken == NPIX - 1);
                    exp_q.push_back(e);
                    m_taken++;
                    if (m_taken == NPIX) begin
                        m_phase = 2;
                        m_frames++;
                    end
                end
                default: m_phase = 0;
            endcase
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            hold_a = 0;
            hold_d = 0;
        end else begin
            chk("in_ready", int'(in_ready), int'(m_phase == 1));
            chk("busy", int'(busy), int'(m_phase != 0));
            if (frame_done) n_fd++;
            if (mem_we) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_write", int'(mem_we), 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("addr", int'(mem_addr), e.addr);
                    chk("wdata", int'(mem_wdata), e.data);
                    chk("frame_done", int'(frame_done), int'(e.last));
                    chk("write_lag", exp_q.size(), 0);
                    hold_a = e.addr;
                    hold_d = e.data;
                end
            end else begin
                chk("missing_write", exp_q.size(), 0);
                chk("frame_done_nowrite", int'(frame_done), 0);
                chk("addr_hold", int'(mem_addr), hold_a);
                chk("wdata_hold", int'(mem_wdata), hold_d);
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start    = 1'b1;
        in_valid = 1'b0;
        tick();
        start = 1'b0;
    endtask

    task automatic feed(input int target, input int vpct, input int mid_start);
        int budget = 0;
        bit fired  = 1'b0;
        while (m_taken < target && budget < 2000) begin
            in_valid = (int'($urandom_range(0, 99)) < vpct);
            in_data  = gen_data();
            start    = (!fired && mid_start >= 0 && m_taken == mid_start);
            if (start) fired = 1'b1;
            tick();
            budget++;
        end
        in_valid = 1'b0;
        start    = 1'b0;
        if (budget >= 2000) begin
            n_vec++;
            n_err++;
            $display("FAIL feed_timeout: accepted %0d, required %0d", m_taken, target);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) tick();
        reset = 1'b0;
        tick();
        chk("rst_mem_we", int'(mem_we), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        chk("rst_mem_wdata", int'(mem_wdata), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_frame_done", int'(frame_done), 0);

        // valid while idle must be ignored
        in_valid = 1'b1;
        repeat (5) begin
            in_data = gen_data();
            tick();
        end
        in_valid = 1'b0;

        // back-to-back frame of constant 200
        pulse_start();
        repeat (NPIX) begin
            in_valid = 1'b1;
            in_data  = ACC_W'(200);
            tick();
        end
        in_valid = 1'b0;
        repeat (2) tick();

        // rounding and saturation corners, then random fill
        pulse_start();
        foreach (rq_vals[i]) begin
            in_valid = 1'b1;
            in_data  = ACC_W'(rq_vals[i]);
            tick();
        end
        feed(NPIX, 70, -1);
        repeat (2) tick();

        // bubbles
        pulse_start();
        foreach (bub[i]) begin
            in_valid = bub[i];
            in_data  = gen_data();
            tick();
        end
        feed(NPIX, 100, -1);
        repeat (2) tick();

        // start pulse after pixel 5 is ignored
        pulse_start();
        feed(NPIX, 100, 6);
        repeat (2) tick();

        // reset right after the handshake of pixel 7
        pulse_start();
        feed(7, 100, -1);
        in_valid = 1'b1;
        in_data  = gen_data();
        @(posedge clk);
        #2 reset = 1'b1;
        in_valid = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        tick();
        pulse_start();
        feed(NPIX, 100, -1);
        repeat (2) tick();

        for (int f = 0; f < 8; f++) begin
            repeat ($urandom_range(0, 3)) tick();
            pulse_start();
            feed(NPIX, int'($urandom_range(30, 100)),
                 ($urandom_range(0, 1) != 0) ? int'($urandom_range(1, 14)) : -1);
            repeat (2) tick();
        end

        repeat (3) tick();
        chk("frame_done_count", n_fd, m_frames);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
